// File: rtl/button_pkg.sv
// Shared types and constants for the push-button conditioning path.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'b00,
        PRESS_WAIT   = 2'b01,
        PRESSED      = 2'b11,
        RELEASE_WAIT = 2'b10
    } state_t;

    localparam int unsigned CLK_HZ        = 50_000_000;
    localparam int unsigned CYCLES_PER_MS = CLK_HZ / 1000;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module bit_sync #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            chain <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = chain[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Synchronises and debounces a raw push-button into a clean level plus press/release pulses.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press_pulse,
    output logic btn_release_pulse
);

    localparam int unsigned CNT_W       = clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit          INACTIVE    = (ACTIVE_LOW != 0);

    logic             sync_out;
    logic             s_in;
    state_t           state;
    state_t           state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             press_d;
    logic             release_d;

    bit_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (INACTIVE)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (btn_raw),
        .dout    (sync_out)
    );

    assign s_in = sync_out ^ INACTIVE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= RELEASED;
            cnt               <= '0;
            btn_press_pulse   <= 1'b0;
            btn_release_pulse <= 1'b0;
        end else begin
            state             <= state_d;
            cnt               <= cnt_d;
            btn_press_pulse   <= press_d;
            btn_release_pulse <= release_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            RELEASED: begin
                if (s_in) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s_in) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (!s_in) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (s_in) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    // Encoding puts the level in state[1], so btn_level comes straight off a flop.
    always_comb begin
        btn_level = state[1];
        press_d   = (state == PRESS_WAIT) && (state_d == PRESSED);
        release_d = (state == RELEASE_WAIT) && (state_d == RELEASED);
    end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with an 8-cycle debounce window.
module tb_button_debounce;

    logic clk;
    logic reset_n;
    logic btn_raw;
    logic btn_level;
    logic btn_press_pulse;
    logic btn_release_pulse;

    int checks;
    int errors;

    button_debounce #(
        .DEBOUNCE_CYCLES (8),
        .SYNC_STAGES     (2),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .btn_raw           (btn_raw),
        .btn_level         (btn_level),
        .btn_press_pulse   (btn_press_pulse),
        .btn_release_pulse (btn_release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        btn_raw = 1'b1;
        #3;
        checks++;
        if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_values got %b want 000", {btn_level, btn_press_pulse, btn_release_pulse});
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL reset_release_idle edge %0d got %b want 000", k,
                         {btn_level, btn_press_pulse, btn_release_pulse});
            end
        end
    endtask

    task automatic test_press_release();
        btn_raw = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++;
            if (btn_level !== (k >= 11) || btn_press_pulse !== (k == 11) || btn_release_pulse !== 1'b0) begin
                errors++;
                $display("FAIL press_latency edge %0d got lvl=%b pp=%b rp=%b want lvl=%b pp=%b rp=0", k,
                         btn_level, btn_press_pulse, btn_release_pulse, (k >= 11), (k == 11));
            end
        end
        btn_raw = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++;
            if (btn_level !== (k < 11) || btn_release_pulse !== (k == 11) || btn_press_pulse !== 1'b0) begin
                errors++;
                $display("FAIL release_latency edge %0d got lvl=%b pp=%b rp=%b want lvl=%b pp=0 rp=%b", k,
                         btn_level, btn_press_pulse, btn_release_pulse, (k < 11), (k == 11));
            end
        end
    endtask

    task automatic test_press_bounce();
        for (int i = 0; i < 30; i++) begin
            btn_raw = (i < 5) ? 1'b0 : (i < 7) ? 1'b1 : (i < 10) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL press_bounce cycle %0d got %b want 000", i,
                         {btn_level, btn_press_pulse, btn_release_pulse});
            end
        end
    endtask

    task automatic test_release_bounce();
        btn_raw = 1'b0;
        for (int k = 1; k <= 14; k++) tick();
        checks++;
        if (btn_level !== 1'b1) begin
            errors++;
            $display("FAIL release_bounce_setup got lvl=%b want 1", btn_level);
        end
        for (int i = 0; i < 27; i++) begin
            btn_raw = (i < 7) ? 1'b1 : 1'b0;
            tick();
            checks++;
            if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b100) begin
                errors++;
                $display("FAIL release_bounce cycle %0d got %b want 100", i,
                         {btn_level, btn_press_pulse, btn_release_pulse});
            end
        end
    endtask

    task automatic test_held_through_reset();
        btn_raw = 1'b0;
        reset_n = 1'b0;
        #2;
        checks++;
        if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL held_reset_assert got %b want 000", {btn_level, btn_press_pulse, btn_release_pulse});
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            checks++;
            if (btn_level !== (k >= 11) || btn_press_pulse !== (k == 11) || btn_release_pulse !== 1'b0) begin
                errors++;
                $display("FAIL held_reset_press edge %0d got lvl=%b pp=%b rp=%b want lvl=%b pp=%b rp=0", k,
                         btn_level, btn_press_pulse, btn_release_pulse, (k >= 11), (k == 11));
            end
        end
    endtask

    task automatic test_reset_mid();
        reset_n = 1'b0;
        btn_raw = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        // PRESS_WAIT entered on edge 3, so cnt reads 5 after edge 8.
        btn_raw = 1'b0;
        for (int k = 1; k <= 8; k++) tick();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_wait got %b want 000", {btn_level, btn_press_pulse, btn_release_pulse});
        end
        btn_raw = 1'b1;
        tick();
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_after edge %0d got %b want 000", k,
                         {btn_level, btn_press_pulse, btn_release_pulse});
            end
        end
        btn_raw = 1'b0;
        for (int k = 1; k <= 14; k++) tick();
        checks++;
        if (btn_level !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pressed_setup got lvl=%b want 1", btn_level);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_pressed got %b want 000", {btn_level, btn_press_pulse, btn_release_pulse});
        end
        btn_raw = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++;
            if ({btn_level, btn_press_pulse, btn_release_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL reset_mid_pressed_after edge %0d got %b want 000", k,
                         {btn_level, btn_press_pulse, btn_release_pulse});
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset_n = 1'b0;
        btn_raw = 1'b1;
        test_reset();
        test_press_release();
        test_press_bounce();
        test_release_bounce();
        test_held_through_reset();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
